// File: rtl/pc_unit_if.sv
// pc_unit_if: branch-resolution inputs and fetch-address outputs of the program-counter unit.
interface pc_unit_if #(
  parameter int ADDR_W   = 64,
  parameter int COND_W   = 19,
  parameter int UNCOND_W = 26
);
  logic                stall;
  logic                br_valid;
  logic                br_taken;
  logic                uncond_br;
  logic                br_reg_en;
  logic                link;
  logic                ret;
  logic [COND_W-1:0]   cond_imm;
  logic [UNCOND_W-1:0] br_imm;
  logic [ADDR_W-1:0]   reg_target;
  logic [ADDR_W-1:0]   counter;
  logic                redirect_pending;
  logic                misalign;
  logic                ras_empty;
  modport master (
    output stall, br_valid, br_taken, uncond_br, br_reg_en, link, ret, cond_imm, br_imm, reg_target,
    input  counter, redirect_pending, misalign, ras_empty
  );
  modport slave (
    input  stall, br_valid, br_taken, uncond_br, br_reg_en, link, ret, cond_imm, br_imm, reg_target,
    output counter, redirect_pending, misalign, ras_empty
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program counter with stall, one-entry redirect buffer, indirect jumps and
// an optional return-address stack built when PC_RAS_EN is defined.
module pc_unit #(
  parameter int              ADDR_W    = 64,
  parameter int              COND_W    = 19,
  parameter int              UNCOND_W  = 26,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int              RAS_DEPTH = 4
) (
  input logic       clk,
  input logic       reset,
  pc_unit_if.slave  bus
);
  logic [ADDR_W-1:0] counter_q, counter_d, pend_tgt_q, pend_tgt_d;
  logic [ADDR_W-1:0] target, seq_pc, offset, ras_top;
  logic              pend_q, pend_d, mis_q, mis_d;
  logic              take, pop, ind, ras_empty_w;
  assign take   = bus.br_valid & bus.br_taken;
  assign ind    = bus.br_reg_en | (bus.ret & ~pop);
  assign seq_pc = counter_q + ADDR_W'(4);
  always_comb begin
    offset     = bus.uncond_br ? {{(ADDR_W-UNCOND_W){bus.br_imm[UNCOND_W-1]}}, bus.br_imm}
                               : {{(ADDR_W-COND_W){bus.cond_imm[COND_W-1]}}, bus.cond_imm};
    target     = pop ? ras_top : ind ? {bus.reg_target[ADDR_W-1:2], 2'b00} : counter_q + (offset << 2);
    counter_d  = bus.stall ? counter_q : take ? target : pend_q ? pend_tgt_q : seq_pc;
    pend_d     = bus.stall & (take | pend_q);
    pend_tgt_d = (bus.stall & take) ? target : pend_tgt_q;
    mis_d      = take & ind & (|bus.reg_target[1:0]);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter_q  <= RESET_VEC;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      mis_q      <= 1'b0;
    end else begin
      counter_q  <= counter_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      mis_q      <= mis_d;
    end
  end
`ifdef PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [ADDR_W-1:0] ras_d [RAS_DEPTH];
  logic [PW-1:0]     sp_q, sp_d;
  logic [PW:0]       cnt_q, cnt_d;
  assign ras_empty_w = cnt_q == '0;
  assign ras_top     = ras_q[sp_q - 1'b1];
  assign pop         = bus.ret & ~ras_empty_w;
  // sp points at the next free slot; when full it points at the oldest entry, so a push overwrites it
  always_comb begin
    ras_d = ras_q;
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (take & bus.link & pop) ras_d[sp_q - 1'b1] = seq_pc;
    else if (take & bus.link) begin
      ras_d[sp_q] = seq_pc;
      sp_d        = sp_q + 1'b1;
      cnt_d       = (cnt_q == (PW+1)'(RAS_DEPTH)) ? cnt_q : cnt_q + 1'b1;
    end else if (take & pop) begin
      sp_d  = sp_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) ras_q <= ras_d;
`else
  assign ras_empty_w = 1'b1;
  assign ras_top     = '0;
  assign pop         = 1'b0;
`endif
  assign bus.counter          = counter_q;
  assign bus.redirect_pending = pend_q;
  assign bus.misalign         = mis_q;
  assign bus.ras_empty        = ras_empty_w;
endmodule
